// File: rtl/ahb_sram_subordinate_if.sv
// AHB-Lite bus bundle between the upstream adapter (master)
// and the SRAM subordinate model (slave).
interface ahb_sram_subordinate_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    HSEL;
    logic [1:0]              HTRANS;
    logic                    HWRITE;
    logic [2:0]              HSIZE;
    logic [ADDR_WIDTH-1:0]   HADDR;
    logic [DATA_WIDTH-1:0]   HWDATA;
    logic [DATA_WIDTH/8-1:0] HWSTRB;
    logic                    HREADY;
    logic                    HRESP;
    logic [DATA_WIDTH-1:0]   HRDATA;

    modport master (
        output HSEL, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, HWSTRB,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, HWSTRB,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite SRAM subordinate: wait states, byte-strobe writes,
// two-cycle ERROR responses and a backdoor port.
module ahb_sram_subordinate #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_WORDS   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         nRST,
    ahb_sram_subordinate_if.slave        bus,
    input  logic                         bd_we,
    input  logic [$clog2(MEM_WORDS)-1:0] bd_addr,
    input  logic [DATA_WIDTH-1:0]        bd_wdata,
    output logic [DATA_WIDTH-1:0]        bd_rdata
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(WAIT_CYCLES + 2);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DONE = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    logic [2:0]            state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [IW-1:0]         idx_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic [ADDR_WIDTH-1:0] off;
    logic                  in_range, aligned, legal;
    logic                  ready, accept, commit;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    assign ready  = (state == S_IDLE) || (state == S_DONE) ||
                    (state == S_ERR2);
    assign accept = ready && bus.HSEL && bus.HTRANS[1];

    assign off      = bus.HADDR - BASE_ADDR;
    assign in_range = (bus.HADDR >= BASE_ADDR) &&
                      ((off >> 2) < ADDR_WIDTH'(MEM_WORDS));

    always_comb begin
        unique case (bus.HSIZE)
            3'b000:  aligned = 1'b1;
            3'b001:  aligned = ~bus.HADDR[0];
            3'b010:  aligned = (bus.HADDR[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign legal = in_range && aligned;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            S_WAIT: begin
                if (cnt == CW'(WAIT_CYCLES)) begin
                    state_n = S_DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_ERR1:  state_n = S_ERR2;
            default: state_n = S_IDLE;
        endcase
        // Pipelined acceptance overrides the fall-back to IDLE
        if (accept) begin
            cnt_n = CW'(1);
            if (!legal)
                state_n = S_ERR1;
            else if (WAIT_CYCLES == 0)
                state_n = S_DONE;
            else
                state_n = S_WAIT;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            size_q  <= 3'b000;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                idx_q   <= off[IW+1:2];
                write_q <= bus.HWRITE;
                size_q  <= bus.HSIZE;
            end
        end
    end

    assign commit = (state == S_DONE) && write_q;

    // AHB lanes are applied after the backdoor so the bus wins a clash
    always_ff @(posedge clk) begin
        if (bd_we)
            mem[bd_addr] <= bd_wdata;
        if (commit) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (bus.HWSTRB[i])
                    mem[idx_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
            end
        end
    end

    assign bus.HREADY = ready;
    assign bus.HRESP  = (state == S_ERR1) || (state == S_ERR2);
    assign bus.HRDATA = ((state == S_DONE) && !write_q) ?
                        mem[idx_q] : '0;
    assign bd_rdata   = mem[bd_addr];

    logic unused_ok;
    assign unused_ok = ^{off[1:0], off[ADDR_WIDTH-1:IW+2],
                         bus.HTRANS[0], size_q};
endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Randomised bench for ahb_sram_subordinate against a word-array
// model; a second instance exercises the multi-wait reset case.
module tb_ahb_sram_subordinate;
    localparam int MW = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst1, nrst3;
    logic        bd_we1, bd_we3;
    logic [9:0]  bd_addr1, bd_addr3;
    logic [31:0] bd_wdata1, bd_wdata3, bd_rdata1, bd_rdata3;

    ahb_sram_subordinate_if b1();
    ahb_sram_subordinate_if b3();

    ahb_sram_subordinate #(.WAIT_CYCLES(1)) u1 (
        .clk(clk), .nRST(nrst1), .bus(b1),
        .bd_we(bd_we1), .bd_addr(bd_addr1),
        .bd_wdata(bd_wdata1), .bd_rdata(bd_rdata1)
    );

    ahb_sram_subordinate #(.WAIT_CYCLES(3)) u3 (
        .clk(clk), .nRST(nrst3), .bus(b3),
        .bd_we(bd_we3), .bd_addr(bd_addr3),
        .bd_wdata(bd_wdata3), .bd_rdata(bd_rdata3)
    );

    int passed = 0;
    int total  = 0;
    logic [31:0] model [MW];

    function automatic bit legal_f(input logic [31:0] a,
                                   input logic [2:0] s);
        if (s > 3'd2) return 1'b0;
        return (a < 32'(MW * 4)) && ((a % (32'd1 << s)) == 0);
    endfunction

    function automatic void model_write(input int w,
                                        input logic [31:0] d,
                                        input logic [3:0] st);
        for (int i = 0; i < 4; i++)
            if (st[i]) model[w][8*i +: 8] = d[8*i +: 8];
    endfunction

    task automatic bd1_write(input int w, input logic [31:0] d);
        bd_we1 = 1'b1; bd_addr1 = 10'(w); bd_wdata1 = d;
        @(posedge clk); #1;
        bd_we1 = 1'b0;
        model[w] = d;
        @(negedge clk);
    endtask

    // Single non-pipelined transfer on u1, started at a negedge
    task automatic xfer(input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic collide,
                        output int waits, output logic resp_low,
                        output logic resp_hi, output logic [31:0] rdata);
        int guard;
        b1.HSEL = 1'b1; b1.HTRANS = 2'b10; b1.HWRITE = wr;
        b1.HSIZE = size; b1.HADDR = addr;
        @(posedge clk); #1;
        b1.HSEL = 1'b0; b1.HTRANS = 2'b00;
        b1.HWDATA = wdata; b1.HWSTRB = strb;
        waits = 0; resp_low = 1'b0; guard = 0;
        @(negedge clk);
        while (b1.HREADY !== 1'b1 && guard < 20) begin
            waits++; resp_low = b1.HRESP; guard++;
            @(negedge clk);
        end
        resp_hi = b1.HRESP;
        rdata   = b1.HRDATA;
        if (collide) begin
            bd_we1 = 1'b1; bd_addr1 = addr[11:2]; bd_wdata1 = ~wdata;
        end
        @(posedge clk); #1;
        bd_we1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        nrst1 = 1'b1; nrst3 = 1'b1;
        @(negedge clk);
        bd1_write(3, 32'hCAFEF00D);
        nrst1 = 1'b0;
        b1.HSEL = 1'b1; b1.HTRANS = 2'b10; b1.HWRITE = 1'($urandom);
        b1.HADDR = $urandom; b1.HSIZE = 3'($urandom);
        b1.HWDATA = $urandom; b1.HWSTRB = 4'($urandom);
        #1;
        total++; if (b1.HREADY !== 1'b1) $display("FAIL rst_hready: got %b want 1", b1.HREADY); else passed++;
        total++; if (b1.HRESP !== 1'b0) $display("FAIL rst_hresp: got %b want 0", b1.HRESP); else passed++;
        total++; if (b1.HRDATA !== 32'h0) $display("FAIL rst_hrdata: got %h want 0", b1.HRDATA); else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (b1.HREADY !== 1'b1) $display("FAIL rst_hold_hready: got %b want 1", b1.HREADY); else passed++;
        total++; if (b3.HREADY !== 1'b1) $display("FAIL rst_u3_hready: got %b want 1", b3.HREADY); else passed++;
        b1.HSEL = 1'b0; b1.HTRANS = 2'b00;
        nrst1 = 1'b1;
        @(negedge clk);
        bd_addr1 = 10'd3; #1;
        total++; if (bd_rdata1 !== 32'hCAFEF00D) $display("FAIL rst_retain: got %h want cafef00d", bd_rdata1); else passed++;
        @(negedge clk);
    endtask

    task automatic test_write();
        int w; logic rl, rh; logic [31:0] rd;
        xfer(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 4'hF, 1'b0, w, rl, rh, rd);
        model_write(4, 32'hDEADBEEF, 4'hF);
        total++; if (w !== 1) $display("FAIL wr_waits: got %0d want 1", w); else passed++;
        total++; if (rh !== 1'b0) $display("FAIL wr_resp: got %b want 0", rh); else passed++;
        bd_addr1 = 10'd4; #1;
        total++; if (bd_rdata1 !== 32'hDEADBEEF) $display("FAIL wr_data: got %h want deadbeef", bd_rdata1); else passed++;
    endtask

    task automatic test_strobes();
        int w; logic rl, rh; logic [31:0] rd;
        @(negedge clk);
        bd1_write(4, 32'h11223344);
        xfer(1'b1, 32'h10, 3'b010, 32'hAABBCCDD, 4'b0101, 1'b0, w, rl, rh, rd);
        model_write(4, 32'hAABBCCDD, 4'b0101);
        bd_addr1 = 10'd4; #1;
        total++; if (bd_rdata1 !== 32'h11BB33DD) $display("FAIL strb_bd: got %h want 11bb33dd", bd_rdata1); else passed++;
        @(negedge clk);
        xfer(1'b0, 32'h10, 3'b010, 32'h0, 4'h0, 1'b0, w, rl, rh, rd);
        total++; if (rd !== 32'h11BB33DD) $display("FAIL strb_rd: got %h want 11bb33dd", rd); else passed++;
    endtask

    task automatic test_burst();
        logic hr, dphase, aphase; logic [31:0] rd, exp;
        int issued, got, cycles, last;
        for (int k = 16; k < 32; k++) bd1_write(k, 32'(k) * 32'h01010101);
        b1.HSEL = 1'b1; b1.HTRANS = 2'b10; b1.HWRITE = 1'b0;
        b1.HSIZE = 3'b010; b1.HADDR = 32'h40;
        aphase = 1'b1; dphase = 1'b0;
        issued = 0; got = 0; cycles = 0; last = -1;
        while (got < 16 && cycles < 200) begin
            hr = b1.HREADY; rd = b1.HRDATA;
            @(posedge clk); cycles++; #1;
            if (hr) begin
                if (dphase) begin
                    exp = model[16 + got];
                    total++; if (rd !== exp) $display("FAIL burst_beat%0d: got %h want %h", got, rd, exp); else passed++;
                    got++;
                    if (got == 16) last = cycles;
                end
                dphase = aphase;
                if (aphase) begin
                    issued++;
                    if (issued < 16) b1.HADDR = 32'h40 + 32'(4 * issued);
                    else begin b1.HSEL = 1'b0; b1.HTRANS = 2'b00; aphase = 1'b0; end
                end
            end
            @(negedge clk);
        end
        b1.HSEL = 1'b0; b1.HTRANS = 2'b00;
        total++; if (last != 1 + 16 * 2) $display("FAIL burst_latency: got %0d want %0d", last, 1 + 16 * 2); else passed++;
    endtask

    task automatic test_error();
        int w; logic rl, rh; logic [31:0] rd;
        bd1_write(0, 32'h5A5A0F0F);
        bd1_write(MW - 1, 32'h600DF00D);
        xfer(1'b0, 32'(MW * 4), 3'b010, 32'h0, 4'h0, 1'b0, w, rl, rh, rd);
        total++; if (w !== 1 || rl !== 1'b1) $display("FAIL err_rd_ph1: got waits %0d resp %b want 1/1", w, rl); else passed++;
        total++; if (rh !== 1'b1) $display("FAIL err_rd_ph2: got %b want 1", rh); else passed++;
        total++; if (rd !== 32'h0) $display("FAIL err_rd_data: got %h want 0", rd); else passed++;
        xfer(1'b1, 32'h2, 3'b010, 32'hFFFFFFFF, 4'hF, 1'b0, w, rl, rh, rd);
        total++; if (w !== 1 || rl !== 1'b1 || rh !== 1'b1) $display("FAIL err_wr_resp: got %0d/%b/%b want 1/1/1", w, rl, rh); else passed++;
        bd_addr1 = 10'd0; #1;
        total++; if (bd_rdata1 !== 32'h5A5A0F0F) $display("FAIL err_wr_mem: got %h want 5a5a0f0f", bd_rdata1); else passed++;
        @(negedge clk);
        xfer(1'b0, 32'(MW * 4 - 4), 3'b010, 32'h0, 4'h0, 1'b0, w, rl, rh, rd);
        total++; if (rh !== 1'b0 || rd !== 32'h600DF00D) $display("FAIL last_word: got %b/%h want 0/600df00d", rh, rd); else passed++;
    endtask

    task automatic test_collision();
        int w; logic rl, rh; logic [31:0] rd, d;
        d = $urandom;
        bd1_write(9, 32'h0);
        xfer(1'b1, 32'h24, 3'b010, d, 4'hF, 1'b1, w, rl, rh, rd);
        model_write(9, d, 4'hF);
        bd_addr1 = 10'd9; #1;
        total++; if (bd_rdata1 !== d) $display("FAIL collide: got %h want %h", bd_rdata1, d); else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] nv; int g;
        nv = $urandom | 32'h1;
        bd1_write(8, ~nv);
        b1.HSEL = 1'b1; b1.HTRANS = 2'b10; b1.HWRITE = 1'b1;
        b1.HSIZE = 3'b010; b1.HADDR = 32'h20;
        @(posedge clk); #1;
        b1.HWRITE = 1'b0; b1.HWDATA = nv; b1.HWSTRB = 4'hF;
        g = 0;
        do begin @(negedge clk); g++; end while (b1.HREADY !== 1'b1 && g < 20);
        @(posedge clk); #1;
        b1.HSEL = 1'b0; b1.HTRANS = 2'b00;
        g = 0;
        do begin @(negedge clk); g++; end while (b1.HREADY !== 1'b1 && g < 20);
        model[8] = nv;
        total++; if (b1.HRDATA !== nv) $display("FAIL b2b_read: got %h want %h", b1.HRDATA, nv); else passed++;
        @(negedge clk);
    endtask

    task automatic test_random();
        int w, r, word; logic rl, rh, wr, lg;
        logic [31:0] addr, d, rd, exp; logic [2:0] sz; logic [3:0] st;
        for (int k = 0; k < 64; k++) bd1_write(k, $urandom);
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            word = $urandom_range(0, 63);
            sz = 3'b010;
            addr = 32'(word * 4);
            if (r == 0) addr = 32'(MW * 4 + 4 * $urandom_range(0, 255));
            if (r == 1) begin
                addr = addr + 32'($urandom_range(1, 3));
                sz = 3'($urandom_range(0, 2));
            end
            if (r == 2) sz = 3'($urandom_range(3, 7));
            wr = 1'($urandom); d = $urandom; st = 4'($urandom);
            lg = legal_f(addr, sz);
            exp = (lg && !wr) ? model[addr[11:2]] : 32'h0;
            xfer(wr, addr, sz, d, st, 1'b0, w, rl, rh, rd);
            if (lg && wr) model_write(int'(addr[11:2]), d, st);
            total++; if (w !== 1 || rh !== !lg) $display("FAIL rnd%0d_resp: got %0d/%b want 1/%b", n, w, rh, !lg); else passed++;
            if (!wr) begin
                total++; if (rd !== exp) $display("FAIL rnd%0d_rdata: got %h want %h", n, rd, exp); else passed++;
            end
        end
        for (int k = 0; k < 64; k++) begin
            bd_addr1 = 10'(k); #1;
            total++; if (bd_rdata1 !== model[k]) $display("FAIL rnd_mem%0d: got %h want %h", k, bd_rdata1, model[k]); else passed++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        logic [31:0] old;
        old = $urandom;
        bd_we3 = 1'b1; bd_addr3 = 10'd5; bd_wdata3 = old;
        @(posedge clk); #1; bd_we3 = 1'b0;
        @(negedge clk);
        b3.HSEL = 1'b1; b3.HTRANS = 2'b10; b3.HWRITE = 1'b1;
        b3.HSIZE = 3'b010; b3.HADDR = 32'h14;
        @(posedge clk); #1;
        b3.HSEL = 1'b0; b3.HTRANS = 2'b00;
        b3.HWDATA = 32'h12345678; b3.HWSTRB = 4'hF;
        @(posedge clk); #1;
        total++; if (b3.HREADY !== 1'b0) $display("FAIL midop_wait: got %b want 0", b3.HREADY); else passed++;
        nrst3 = 1'b0; #1;
        total++; if (b3.HREADY !== 1'b1) $display("FAIL midop_hready: got %b want 1", b3.HREADY); else passed++;
        repeat (3) @(posedge clk);
        @(negedge clk); nrst3 = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        bd_addr3 = 10'd5; #1;
        total++; if (bd_rdata3 !== old) $display("FAIL midop_mem: got %h want %h", bd_rdata3, old); else passed++;
    endtask

    initial begin
        nrst1 = 1'b0; nrst3 = 1'b0;
        bd_we1 = 1'b0; bd_addr1 = '0; bd_wdata1 = '0;
        bd_we3 = 1'b0; bd_addr3 = '0; bd_wdata3 = '0;
        b1.HSEL = 1'b0; b1.HTRANS = 2'b00; b1.HWRITE = 1'b0;
        b1.HSIZE = 3'b010; b1.HADDR = '0; b1.HWDATA = '0; b1.HWSTRB = '0;
        b3.HSEL = 1'b0; b3.HTRANS = 2'b00; b3.HWRITE = 1'b0;
        b3.HSIZE = 3'b010; b3.HADDR = '0; b3.HWDATA = '0; b3.HWSTRB = '0;
        test_reset();
        test_write();
        test_strobes();
        test_burst();
        test_error();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
